// File: rtl/ex_mem.sv
// EX/MEM pipeline register. It owns the single in-flight dcache request and stalls everything upstream until dhit.
// Latency: EX to mem_* is 1 cycle, and load data arrives 1 cycle after dhit. Backpressure: mem_busy, ihit gating, HALTED.
module ex_mem #(
  parameter int WORD_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              flush,
  input  logic [WORD_W-1:0] ex_npc,
  input  logic [WORD_W-1:0] ex_imemload,
  input  logic [WORD_W-1:0] ex_aluout,
  input  logic [WORD_W-1:0] ex_rdat2,
  input  logic [REG_AW-1:0] ex_wsel,
  input  logic              ex_RegWr,
  input  logic              ex_MemtoReg,
  input  logic              ex_dREN,
  input  logic              ex_dWEN,
  input  logic              ex_jal,
  input  logic              ex_halt,
  input  logic [WORD_W-1:0] dmemload,
  output logic [WORD_W-1:0] mem_npc,
  output logic [WORD_W-1:0] mem_imemload,
  output logic [WORD_W-1:0] mem_aluout,
  output logic [WORD_W-1:0] mem_rdat2,
  output logic [REG_AW-1:0] mem_wsel,
  output logic              mem_RegWr,
  output logic              mem_MemtoReg,
  output logic              mem_jal,
  output logic              mem_halt,
  output logic              dREN,
  output logic              dWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] mem_dmemload,
  output logic              mem_busy,
  output logic [CNT_W-1:0]  memwait_cnt
);

  typedef enum logic [1:0] {IDLE, MEMREQ, HALTED} state_t;

  typedef struct packed {
    logic [WORD_W-1:0] npc;
    logic [WORD_W-1:0] imemload;
    logic [WORD_W-1:0] aluout;
    logic [WORD_W-1:0] rdat2;
    logic [REG_AW-1:0] wsel;
    logic              regwr;
    logic              memtoreg;
    logic              dren;
    logic              dwen;
    logic              jal;
    logic              halt;
  } exmem_t;

  state_t state, next_state, cap_state;
  exmem_t mem_q, ex_d;
  logic   cap;
  logic   req_done;

  assign ex_d = '{npc:      ex_npc,
                  imemload: ex_imemload,
                  aluout:   ex_aluout,
                  rdat2:    ex_rdat2,
                  wsel:     ex_wsel,
                  regwr:    ex_RegWr,
                  memtoreg: ex_MemtoReg,
                  dren:     ex_dREN,
                  dwen:     ex_dWEN,
                  jal:      ex_jal,
                  halt:     ex_halt};

  assign cap      = ihit && !mem_busy && (state != HALTED);
  assign req_done = (state == MEMREQ) && dhit;

  // State a freshly captured instruction (or bubble) leads to
  always_comb begin
    cap_state = IDLE;
    if (!flush) begin
      if (ex_dREN || ex_dWEN) cap_state = MEMREQ;
      else if (ex_halt)       cap_state = HALTED;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (cap) next_state = cap_state;
      MEMREQ:  if (dhit) next_state = cap ? cap_state : (mem_q.halt ? HALTED : IDLE);
      HALTED:  next_state = HALTED;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dREN     = 1'b0;
    dWEN     = 1'b0;
    mem_busy = 1'b0;
    if (state == MEMREQ) begin
      dREN     = mem_q.dren;
      dWEN     = mem_q.dwen;
      mem_busy = !dhit;
    end
  end

  // A same-edge capture overwrites the request bits, so they never re-fire
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      mem_q <= '0;
    end else if (cap) begin
      mem_q <= flush ? '0 : ex_d;
    end else if (req_done) begin
      mem_q.dren <= 1'b0;
      mem_q.dwen <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                       mem_dmemload <= '0;
    else if (req_done && mem_q.dren) mem_dmemload <= dmemload;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                               memwait_cnt <= '0;
    else if (mem_busy && (memwait_cnt != '1)) memwait_cnt <= memwait_cnt + 1'b1;
  end

  assign mem_npc      = mem_q.npc;
  assign mem_imemload = mem_q.imemload;
  assign mem_aluout   = mem_q.aluout;
  assign mem_rdat2    = mem_q.rdat2;
  assign mem_wsel     = mem_q.wsel;
  assign mem_RegWr    = mem_q.regwr;
  assign mem_MemtoReg = mem_q.memtoreg;
  assign mem_jal      = mem_q.jal;
  assign mem_halt     = mem_q.halt;
  assign dmemaddr     = mem_q.aluout;
  assign dmemstore    = mem_q.rdat2;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: a per-cycle reference model plus literal spot checks.
// A second instance with a 4-bit counter shares the stimulus to exercise saturation.
module tb_ex_mem;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic        ihit, dhit, flush;
  logic [31:0] ex_npc, ex_imemload, ex_aluout, ex_rdat2, dmemload;
  logic [4:0]  ex_wsel;
  logic        ex_RegWr, ex_MemtoReg, ex_dREN, ex_dWEN, ex_jal, ex_halt;

  logic [31:0] mem_npc, mem_imemload, mem_aluout, mem_rdat2, dmemaddr, dmemstore, mem_dmemload;
  logic [4:0]  mem_wsel;
  logic        mem_RegWr, mem_MemtoReg, mem_jal, mem_halt, dREN, dWEN, mem_busy;
  logic [15:0] memwait_cnt;

  logic [31:0] s_npc, s_imemload, s_aluout, s_rdat2, s_dmemaddr, s_dmemstore, s_dmemload;
  logic [4:0]  s_wsel;
  logic        s_RegWr, s_MemtoReg, s_jal, s_halt, s_dREN, s_dWEN, s_busy;
  logic [3:0]  s_memwait_cnt;

  ex_mem #(.WORD_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .ex_npc(ex_npc), .ex_imemload(ex_imemload), .ex_aluout(ex_aluout), .ex_rdat2(ex_rdat2),
    .ex_wsel(ex_wsel), .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg), .ex_dREN(ex_dREN),
    .ex_dWEN(ex_dWEN), .ex_jal(ex_jal), .ex_halt(ex_halt), .dmemload(dmemload),
    .mem_npc(mem_npc), .mem_imemload(mem_imemload), .mem_aluout(mem_aluout), .mem_rdat2(mem_rdat2),
    .mem_wsel(mem_wsel), .mem_RegWr(mem_RegWr), .mem_MemtoReg(mem_MemtoReg), .mem_jal(mem_jal),
    .mem_halt(mem_halt), .dREN(dREN), .dWEN(dWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_dmemload(mem_dmemload), .mem_busy(mem_busy), .memwait_cnt(memwait_cnt));

  ex_mem #(.WORD_W(32), .REG_AW(5), .CNT_W(4)) u_sat (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .flush(flush),
    .ex_npc(ex_npc), .ex_imemload(ex_imemload), .ex_aluout(ex_aluout), .ex_rdat2(ex_rdat2),
    .ex_wsel(ex_wsel), .ex_RegWr(ex_RegWr), .ex_MemtoReg(ex_MemtoReg), .ex_dREN(ex_dREN),
    .ex_dWEN(ex_dWEN), .ex_jal(ex_jal), .ex_halt(ex_halt), .dmemload(dmemload),
    .mem_npc(s_npc), .mem_imemload(s_imemload), .mem_aluout(s_aluout), .mem_rdat2(s_rdat2),
    .mem_wsel(s_wsel), .mem_RegWr(s_RegWr), .mem_MemtoReg(s_MemtoReg), .mem_jal(s_jal),
    .mem_halt(s_halt), .dREN(s_dREN), .dWEN(s_dWEN), .dmemaddr(s_dmemaddr), .dmemstore(s_dmemstore),
    .mem_dmemload(s_dmemload), .mem_busy(s_busy), .memwait_cnt(s_memwait_cnt));

  int checks = 0;
  int errors = 0;

  // Reference model: the latched instruction, whether a request is outstanding, and whether we halted
  typedef struct {
    logic [31:0] npc, imem, alu, rdat2;
    logic [4:0]  wsel;
    logic        regwr, m2r, rd, wr, jal, halt;
  } ins_t;

  ins_t        m;
  logic        pend, halted;
  logic [31:0] m_load;
  int unsigned w16, w4;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m      = '{default: '0};
    pend   = 1'b0;
    halted = 1'b0;
    m_load = '0;
    w16    = 0;
    w4     = 0;
  endtask

  task automatic model_update();
    ins_t nx;
    if (!nRST) begin
      model_reset();
      return;
    end
    if (halted) return;
    if (pend && !dhit) begin
      if (w16 < 65535) w16++;
      if (w4 < 15) w4++;
      return;
    end
    if (pend && m.rd) m_load = dmemload;
    if (ihit) begin
      if (flush) begin
        m      = '{default: '0};
        pend   = 1'b0;
        halted = 1'b0;
      end else begin
        nx = '{npc: ex_npc, imem: ex_imemload, alu: ex_aluout, rdat2: ex_rdat2, wsel: ex_wsel,
               regwr: ex_RegWr, m2r: ex_MemtoReg, rd: ex_dREN, wr: ex_dWEN, jal: ex_jal, halt: ex_halt};
        m      = nx;
        pend   = ex_dREN || ex_dWEN;
        halted = !pend && ex_halt;
      end
    end else if (pend) begin
      pend   = 1'b0;
      halted = m.halt;
    end
  endtask

  task automatic check_all();
    chk("npc", mem_npc, m.npc);
    chk("imemload", mem_imemload, m.imem);
    chk("aluout", mem_aluout, m.alu);
    chk("rdat2", mem_rdat2, m.rdat2);
    chk("wsel", mem_wsel, m.wsel);
    chk("RegWr", mem_RegWr, m.regwr);
    chk("MemtoReg", mem_MemtoReg, m.m2r);
    chk("jal", mem_jal, m.jal);
    chk("halt", mem_halt, m.halt);
    chk("dREN", dREN, pend && m.rd);
    chk("dWEN", dWEN, pend && m.wr);
    chk("dmemaddr", dmemaddr, m.alu);
    chk("dmemstore", dmemstore, m.rdat2);
    chk("dmemload", mem_dmemload, m_load);
    chk("busy", mem_busy, pend && !dhit);
    chk("memwait", memwait_cnt, w16);
    chk("sat_memwait", s_memwait_cnt, w4);
    chk("sat_dREN", s_dREN, pend && m.rd);
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic set_ex(input logic [31:0] npc, imem, alu, rd2, input logic [4:0] ws,
                        input logic regwr, m2r, rd, wr, jal, halt);
    ex_npc = npc; ex_imemload = imem; ex_aluout = alu; ex_rdat2 = rd2; ex_wsel = ws;
    ex_RegWr = regwr; ex_MemtoReg = m2r; ex_dREN = rd; ex_dWEN = wr; ex_jal = jal; ex_halt = halt;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1, "timeout");
  end

  initial begin
    ihit = 0; dhit = 0; flush = 0; dmemload = '0;
    set_ex('0, '0, '0, '0, '0, 0, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    tick();
    chk("rst_aluout", mem_aluout, 32'h0);
    chk("rst_memwait", memwait_cnt, 16'h0);
    nRST = 1'b1;

    // ALU op
    set_ex(32'h4, 32'h2000_0001, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 0, 0, 0);
    ihit = 1;
    tick();
    #1;
    chk("alu_aluout", mem_aluout, 32'h1234);
    chk("alu_wsel", mem_wsel, 5'd5);
    chk("alu_dREN", dREN, 1'b0);
    chk("alu_busy", mem_busy, 1'b0);

    // Flush in IDLE
    set_ex(32'h8, 32'h1111_1111, 32'h55, 32'h66, 5'd3, 1, 1, 0, 0, 1, 0);
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("flush_aluout", mem_aluout, 32'h0);
    chk("flush_wsel", mem_wsel, 5'd0);
    chk("flush_jal", mem_jal, 1'b0);

    // Load, three-cycle miss
    set_ex(32'hC, 32'h8C22_0100, 32'h100, 32'h0, 5'd2, 1, 1, 1, 0, 0, 0);
    tick();
    set_ex(32'h10, 32'h0, 32'hBAD, 32'hBAD, 5'd30, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("miss_dREN", dREN, 1'b1);
      chk("miss_busy", mem_busy, 1'b1);
      tick();
    end
    chk("miss_cnt", memwait_cnt, 16'd3);
    dhit = 1; dmemload = 32'hDEAD_BEEF; ihit = 0;
    tick();
    dhit = 0;
    #1;
    chk("load_data", mem_dmemload, 32'hDEAD_BEEF);
    chk("load_dREN_off", dREN, 1'b0);

    // Store completing on the same edge as a new ALU capture
    ihit = 1;
    set_ex(32'h14, 32'hAC00_0200, 32'h200, 32'hA5A5_A5A5, 5'd0, 0, 0, 0, 1, 0, 0);
    tick();
    set_ex(32'h18, 32'h0000_7020, 32'h77, 32'h0, 5'd7, 1, 0, 0, 0, 0, 0);
    #1;
    chk("st_dWEN", dWEN, 1'b1);
    chk("st_data", dmemstore, 32'hA5A5_A5A5);
    tick();
    dhit = 1; dmemload = 32'h1111_1111;
    tick();
    dhit = 0;
    #1;
    chk("st_wsel", mem_wsel, 5'd7);
    chk("st_dWEN_off", dWEN, 1'b0);
    chk("st_busy", mem_busy, 1'b0);
    chk("st_keep_load", mem_dmemload, 32'hDEAD_BEEF);
    chk("st_cnt", memwait_cnt, 16'd4);

    // Flush ignored during MEMREQ
    set_ex(32'h1C, 32'h8C00_0300, 32'h300, 32'h0, 5'd9, 1, 1, 1, 0, 0, 0);
    tick();
    flush = 1;
    set_ex(32'h20, 32'h0, 32'h444, 32'h0, 5'd4, 1, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    chk("fl_dREN", dREN, 1'b1);
    chk("fl_aluout", mem_aluout, 32'h300);
    flush = 0; dhit = 1; dmemload = 32'hCAFE_F00D; ihit = 0;
    tick();
    dhit = 0;
    #1;
    chk("fl_load", mem_dmemload, 32'hCAFE_F00D);
    chk("fl_wsel", mem_wsel, 5'd9);

    // Counter saturation on the 4-bit instance
    ihit = 1;
    set_ex(32'h24, 32'h8C00_0500, 32'h500, 32'h0, 5'd10, 1, 1, 1, 0, 0, 0);
    tick();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt4", s_memwait_cnt, 4'd15);
    chk("sat_cnt16", memwait_cnt, 16'd26);
    dhit = 1; dmemload = 32'h0BAD_F00D; ihit = 0;
    tick();
    dhit = 0;

    // Halt is sticky
    ihit = 1;
    set_ex(32'h28, 32'hFFFF_FFFF, 32'h999, 32'h0, 5'd0, 0, 0, 0, 0, 0, 1);
    tick();
    set_ex(32'h2C, 32'h1234_5678, 32'hABC, 32'h1, 5'd1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    #1;
    chk("halt_flag", mem_halt, 1'b1);
    chk("halt_aluout", mem_aluout, 32'h999);
    chk("halt_dREN", dREN, 1'b0);
    nRST = 1'b0;
    model_reset();
    #1;
    chk("halt_rst_flag", mem_halt, 1'b0);
    chk("halt_rst_aluout", mem_aluout, 32'h0);
    tick();
    nRST = 1'b1;

    // Reset asserted mid-request
    set_ex(32'h30, 32'h8C00_0400, 32'h400, 32'h0, 5'd12, 1, 1, 1, 0, 0, 0);
    tick();
    #1;
    chk("mid_dREN_on", dREN, 1'b1);
    #1;
    nRST = 1'b0;
    model_reset();
    #1;
    chk("mid_dREN_off", dREN, 1'b0);
    chk("mid_cnt", memwait_cnt, 16'h0);
    @(negedge CLK);
    ihit = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
